// File: rtl/serial_dshot_mux_ctrl.sv
// rtl/serial_dshot_mux_ctrl.sv - Wishbone-controlled glitch-safe Serial/DSHOT motor pin mux sequencer
module serial_dshot_mux_ctrl #(
    parameter int CLK_FREQ_HZ     = 72_000_000,
    parameter int BAUD            = 115200,
    parameter int GUARD_US        = 100,
    parameter int IDLE_BITS       = 20,
    parameter int IDLE_TIMEOUT_MS = 1000
) (
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [7:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    input  logic        i_usb_uart_rx,
    input  logic        i_esc_rx,
    output logic        o_mux_sel,
    output logic        o_dshot_en,
    output logic        o_pt_en,
    output logic        o_motor_hold,
    output logic        o_hold_level
);
    localparam longint GUARD_CYCLES   = longint'(CLK_FREQ_HZ) / 1_000_000 * GUARD_US;
    localparam longint IDLE_CYCLES    = longint'(IDLE_BITS) * CLK_FREQ_HZ / BAUD;
    localparam longint TIMEOUT_CYCLES = longint'(CLK_FREQ_HZ) / 1000 * IDLE_TIMEOUT_MS;
    localparam longint MAX_GI         = (GUARD_CYCLES > IDLE_CYCLES) ? GUARD_CYCLES : IDLE_CYCLES;
    localparam longint MAX_CYCLES     = (MAX_GI > TIMEOUT_CYCLES) ? MAX_GI : TIMEOUT_CYCLES;
    localparam int     CNT_W          = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX   = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    localparam logic [7:0] ADR_CTRL   = 8'h00;
    localparam logic [7:0] ADR_STATUS = 8'h04;

    typedef enum logic [2:0] {
        ST_DSHOT,
        ST_TO_PT_GUARD,
        ST_PASSTHROUGH,
        ST_WAIT_IDLE,
        ST_TO_DS_GUARD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_nxt;
    logic [CNT_W-1:0] idle_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic             forced;
    logic             forced_nxt;
    logic             switch_done;
    logic [7:0]       sw_count;
    logic             req_mode;
    logic [1:0]       usb_sync;
    logic [1:0]       esc_sync;
    logic             line_idle;
    logic             busy;
    logic             wb_hit;
    logic [31:0]      rd_data;
    logic             unused_wb_bits;

    assign unused_wb_bits = ^{i_wb_sel[3:1], i_wb_dat[31:1]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    assign line_idle = usb_sync[1] & esc_sync[1];
    assign busy      = (state != ST_DSHOT) && (state != ST_PASSTHROUGH);
    assign cnt_inc   = sat_inc(cnt);
    assign idle_inc  = line_idle ? sat_inc(idle_cnt) : '0;

    // In WAIT_IDLE, cnt is the timeout counter; in the guard states it times the hold.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idle_nxt    = idle_cnt;
        forced_nxt  = forced;
        switch_done = 1'b0;
        case (state)
            ST_DSHOT: begin
                if (!req_mode) begin
                    state_nxt = ST_TO_PT_GUARD;
                    cnt_nxt   = '0;
                end
            end
            ST_TO_PT_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_nxt   = ST_PASSTHROUGH;
                    switch_done = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_PASSTHROUGH: begin
                if (req_mode) begin
                    state_nxt = ST_WAIT_IDLE;
                    cnt_nxt   = '0;
                    idle_nxt  = '0;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_nxt  = cnt_inc;
                idle_nxt = idle_inc;
                if (!req_mode) begin
                    state_nxt = ST_PASSTHROUGH;
                end else if (idle_inc == IDLE_MAX) begin
                    state_nxt  = ST_TO_DS_GUARD;
                    cnt_nxt    = '0;
                    forced_nxt = 1'b0;
                end else if (cnt_inc == TO_MAX) begin
                    state_nxt  = ST_TO_DS_GUARD;
                    cnt_nxt    = '0;
                    forced_nxt = 1'b1;
                end
            end
            ST_TO_DS_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_nxt   = ST_DSHOT;
                    switch_done = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_DSHOT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode state_nxt so they move on the same edge as the state register.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state        <= ST_DSHOT;
            cnt          <= '0;
            idle_cnt     <= '0;
            forced       <= 1'b0;
            sw_count     <= 8'd0;
            usb_sync     <= 2'b11;
            esc_sync     <= 2'b11;
            o_mux_sel    <= 1'b1;
            o_dshot_en   <= 1'b1;
            o_pt_en      <= 1'b0;
            o_motor_hold <= 1'b0;
            o_hold_level <= 1'b0;
        end else begin
            usb_sync <= {usb_sync[0], i_usb_uart_rx};
            esc_sync <= {esc_sync[0], i_esc_rx};
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idle_cnt <= idle_nxt;
            forced   <= forced_nxt;
            if (switch_done) begin
                sw_count <= sw_count + 8'd1;
            end
            case (state_nxt)
                ST_TO_PT_GUARD: begin
                    o_mux_sel    <= 1'b0;
                    o_dshot_en   <= 1'b0;
                    o_pt_en      <= 1'b0;
                    o_motor_hold <= 1'b1;
                    o_hold_level <= 1'b1;
                end
                ST_PASSTHROUGH, ST_WAIT_IDLE: begin
                    o_mux_sel    <= 1'b0;
                    o_dshot_en   <= 1'b0;
                    o_pt_en      <= 1'b1;
                    o_motor_hold <= 1'b0;
                    o_hold_level <= 1'b0;
                end
                ST_TO_DS_GUARD: begin
                    o_mux_sel    <= 1'b1;
                    o_dshot_en   <= 1'b0;
                    o_pt_en      <= 1'b0;
                    o_motor_hold <= 1'b1;
                    o_hold_level <= 1'b0;
                end
                default: begin
                    o_mux_sel    <= 1'b1;
                    o_dshot_en   <= 1'b1;
                    o_pt_en      <= 1'b0;
                    o_motor_hold <= 1'b0;
                    o_hold_level <= 1'b0;
                end
            endcase
        end
    end

    assign wb_hit = i_wb_cyc & i_wb_stb & ~o_wb_ack;

    always_comb begin
        rd_data = '0;
        case (i_wb_adr)
            ADR_CTRL:   rd_data = {31'd0, req_mode};
            ADR_STATUS: rd_data = {16'd0, sw_count, 5'd0, forced, busy, o_mux_sel};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            req_mode <= 1'b1;
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            o_wb_ack <= wb_hit;
            o_wb_dat <= '0;
            if (wb_hit) begin
                if (i_wb_we) begin
                    if ((i_wb_adr == ADR_CTRL) && i_wb_sel[0]) begin
                        req_mode <= i_wb_dat[0];
                    end
                end else begin
                    o_wb_dat <= rd_data;
                end
            end
        end
    end
endmodule
